// File: rtl/tinyalu_pkg.sv
// rtl/tinyalu_pkg.sv - shared types for the TinyALU command driver
// Contents: operation_t opcode encoding, alu_cmd_s queued command payload,
// drv_state_e driver FSM states, state_for_op() opcode-to-state decode.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } alu_cmd_s;

    typedef enum logic [2:0] {
        IDLE,
        NOP,
        RST,
        WAIT,
        RSP
    } drv_state_e;

    // Unassigned encodings 101/110 are treated like no_op: pulse start, no response.
    function automatic drv_state_e state_for_op(input logic [2:0] op);
        drv_state_e s;
        case (op)
            rst_op:                         s = RST;
            add_op, and_op, xor_op, mul_op: s = WAIT;
            default:                        s = NOP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// rtl/tinyalu_cmd_fifo.sv - command FIFO between the command port and the driver FSM
// Ports: clk, reset_n (async active-low); push/push_data/full on the write side;
// pop/pop_data/empty on the read side (pop_data shows the head entry, show-ahead).
// Pointers carry one extra wrap bit so full and empty both come from a pointer compare.
module tinyalu_cmd_fifo
    import tinyalu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  alu_cmd_s push_data,
    output logic     full,
    input  logic     pop,
    output alu_cmd_s pop_data,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    alu_cmd_s       mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/tinyalu_cmd_driver.sv
// rtl/tinyalu_cmd_driver.sv - command front-end driving the TinyALU start/done/reset_n protocol
// Ports: clk, reset_n (async active-low);
//   command in : cmd_valid, cmd_ready, cmd_a[8], cmd_b[8], cmd_op[3]
//   ALU side   : alu_a[8], alu_b[8], alu_op[3], alu_start, alu_reset_n, alu_done, alu_result[16]
//   response   : rsp_valid, rsp_ready, rsp_result[16], rsp_op[3], rsp_err
// Optional feature macro: TINYALU_CMD_TIMEOUT_EN (adds TIMEOUT parameter and WAIT watchdog;
// without it rsp_err is tied 0 and WAIT waits for done indefinitely).
module tinyalu_cmd_driver
    import tinyalu_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int RST_CYCLES = 2
`ifdef TINYALU_CMD_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 16
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    output logic        alu_reset_n,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    drv_state_e     state_q, state_d;
    alu_cmd_s       push_data, head;
    logic           full, empty, pop;
    logic           alu_start_d, alu_reset_n_d, rsp_valid_d;
    logic [15:0]    rsp_result_d;
    logic [2:0]     rsp_op_d;
    logic [RW-1:0]  rst_cnt, rst_cnt_d;

`ifdef TINYALU_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]  tmo_cnt, tmo_cnt_d;
    logic           rsp_err_q, rsp_err_d;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign push_data = '{a: cmd_a, b: cmd_b, op: cmd_op};
    assign cmd_ready = !full;

    tinyalu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (cmd_valid),
        .push_data (push_data),
        .full      (full),
        .pop       (pop),
        .pop_data  (head),
        .empty     (empty)
    );

    // All ALU and response outputs are registered; this block computes their next values.
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        alu_start_d   = alu_start;
        alu_reset_n_d = alu_reset_n;
        rsp_valid_d   = rsp_valid;
        rsp_result_d  = rsp_result;
        rsp_op_d      = rsp_op;
        rst_cnt_d     = rst_cnt;
`ifdef TINYALU_CMD_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt;
        rsp_err_d     = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                alu_reset_n_d = 1'b1;
                if (!empty) begin
                    pop           = 1'b1;
                    state_d       = state_for_op(head.op);
                    alu_start_d   = (state_d != RST);
                    alu_reset_n_d = (state_d != RST);
                    rst_cnt_d     = '0;
`ifdef TINYALU_CMD_TIMEOUT_EN
                    tmo_cnt_d     = '0;
`endif
                end
            end
            NOP: begin
                alu_start_d = 1'b0;
                state_d     = IDLE;
            end
            RST: begin
                if (rst_cnt == RST_LAST) begin
                    alu_reset_n_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    rst_cnt_d = rst_cnt + 1'b1;
                end
            end
            WAIT: begin
                // done is checked first so it wins over a watchdog expiry on the same cycle
                if (alu_done) begin
                    alu_start_d  = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = alu_result;
                    rsp_op_d     = alu_op;
`ifdef TINYALU_CMD_TIMEOUT_EN
                    rsp_err_d    = 1'b0;
`endif
                    state_d      = RSP;
                end
`ifdef TINYALU_CMD_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    alu_start_d  = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = 16'h0000;
                    rsp_op_d     = alu_op;
                    rsp_err_d    = 1'b1;
                    state_d      = RSP;
                end else begin
                    tmo_cnt_d = tmo_cnt + 1'b1;
                end
`endif
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            alu_start   <= 1'b0;
            alu_reset_n <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_op      <= '0;
            rst_cnt     <= '0;
`ifdef TINYALU_CMD_TIMEOUT_EN
            tmo_cnt     <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            alu_start   <= alu_start_d;
            alu_reset_n <= alu_reset_n_d;
            rsp_valid   <= rsp_valid_d;
            rsp_result  <= rsp_result_d;
            rsp_op      <= rsp_op_d;
            rst_cnt     <= rst_cnt_d;
`ifdef TINYALU_CMD_TIMEOUT_EN
            tmo_cnt     <= tmo_cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
            if (pop) begin
                alu_a  <= head.a;
                alu_b  <= head.b;
                alu_op <= head.op;
            end
        end
    end

endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// tb/tb_tinyalu_cmd_driver.sv - self-checking bench for tinyalu_cmd_driver
module tb_tinyalu_cmd_driver;
    import tinyalu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  cmd_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_reset_n;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;

    tinyalu_cmd_driver dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_start   (alu_start),
        .alu_reset_n (alu_reset_n),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_op      (rsp_op),
        .rsp_err     (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  op;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    int   rsp_count = 0;
    int   fixed_lat = 1;   // ALU latency: >0 fixed, 0 random 1..4, -1 never answers
    bit   expect_tmo = 0;
    bit   rr_random = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_result(input logic [7:0] a, input logic [7:0] b,
                                               input logic [2:0] op);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // Behavioural ALU: answers arithmetic ops after a latency counted in start-high cycles.
    initial begin : alu_model
        int cnt;
        int cur_lat;
        alu_done   = 1'b0;
        alu_result = '0;
        cnt        = 0;
        cur_lat    = 1;
        forever begin
            @(negedge clk);
            if (!alu_reset_n || alu_done || !alu_start || !(alu_op inside {[3'd1:3'd4]})) begin
                alu_done = 1'b0;
                cnt      = 0;
            end else begin
                if (cnt == 0) cur_lat = (fixed_lat == 0) ? int'($urandom_range(1, 4)) : fixed_lat;
                cnt++;
                if (cur_lat > 0 && cnt >= cur_lat) begin
                    alu_done   = 1'b1;
                    alu_result = ref_result(alu_a, alu_b, alu_op);
                end
            end
        end
    end

    // Response scoreboard: each accepted response must match the oldest expected one.
    initial begin : rsp_monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && rsp_valid && rsp_ready) begin
                check("rsp_expected_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_result", rsp_result, e.res);
                    check("rsp_op", rsp_op, e.op);
                    check("rsp_err", rsp_err, e.err);
                    rsp_count++;
                end
            end
        end
    end

    initial begin : rr_driver
        forever begin
            @(posedge clk);
            #2;
            if (rr_random) rsp_ready = ($urandom % 2) == 1;
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge or after max_wait cycles.
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input int max_wait, output bit ok);
        rsp_t e;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (ok && op inside {[3'd1:3'd4]}) begin
            e.res = expect_tmo ? 16'h0000 : ref_result(a, b, op);
            e.op  = op;
            e.err = expect_tmo;
            exp_q.push_back(e);
        end
    endtask

    // Counts start-high cycles until the first cycle with rsp_valid; returns at posedge+1.
    task automatic measure(output int n, output bit found, output logic [7:0] sa,
                           output logic [7:0] sb, output logic start_at_rsp);
        n = 0; found = 0; sa = '0; sb = '0; start_at_rsp = 1'bx;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1;
                start_at_rsp = alu_start;
            end else if (alu_start) begin
                if (n == 0) begin sa = alu_a; sb = alu_b; end
                n++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles, input string tag);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, exp_q.size(), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        bit          ok;
        int          n, acc, low, st, rv, base;
        bit          found;
        logic [7:0]  sa, sb;
        logic        s_at;

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;

        // reset values
        #12;
        check("rst_alu_start", alu_start, 0);
        check("rst_alu_reset_n", alu_reset_n, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_op", rsp_op, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_alu_a", {alu_a, alu_b, 5'b0, alu_op}, 0);
        @(posedge clk); #1; reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_cmd_ready", cmd_ready, 1);
        check("rel_alu_reset_n", alu_reset_n, 1);
        @(posedge clk); #1;

        // 1: add, done one clock after start
        rsp_ready = 1'b1; fixed_lat = 1;
        push(8'h02, 8'h03, 3'b001, 5, ok);
        check("t1_push", ok, 1);
        measure(n, found, sa, sb, s_at);
        check("t1_found", found, 1);
        check("t1_start_len", n, 1);
        check("t1_alu_ab", {sa, sb}, 16'h0203);
        check("t1_result", rsp_result, 16'h0005);
        check("t1_op", rsp_op, 3'b001);
        check("t1_err", rsp_err, 0);
        drain(20, "t1_drain");

        // 2: mul, done three clocks after start
        fixed_lat = 3;
        push(8'hFF, 8'hFF, 3'b100, 5, ok);
        measure(n, found, sa, sb, s_at);
        check("t2_start_len", n, 3);
        check("t2_start_low_at_rsp", s_at, 0);
        check("t2_result", rsp_result, 16'hFE01);
        drain(20, "t2_drain");

        // 3: rst_op holds ALU reset low RST_CYCLES clocks, no start, no response
        push(8'h11, 8'h22, 3'b111, 5, ok);
        low = 0; st = 0; rv = 0;
        repeat (10) begin
            @(negedge clk);
            if (!alu_reset_n) low++;
            if (alu_start) st++;
            if (rsp_valid) rv++;
        end
        check("t3_reset_low_len", low, 2);
        check("t3_no_start", st, 0);
        check("t3_no_rsp", rv, 0);
        @(posedge clk); #1;

        // 4: backpressure fills RSP plus FIFO, then drains in order
        rsp_ready = 1'b0; fixed_lat = 1; acc = 0; base = rsp_count;
        for (int i = 0; i < 8; i++) begin
            push(8'($urandom), 8'($urandom), 3'b001, 6, ok);
            acc += int'(ok);
        end
        @(negedge clk);
        check("t4_cmd_ready_low", cmd_ready, 0);
        check("t4_accepted", acc, 5);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain(80, "t4_drain");
        check("t4_rsp_count", rsp_count - base, 5);

        // 5: ALU never answers
        fixed_lat = -1;
`ifdef TINYALU_CMD_TIMEOUT_EN
        expect_tmo = 1;
        push(8'h07, 8'h09, 3'b010, 5, ok);
        measure(n, found, sa, sb, s_at);
        check("t5_start_len", n, 16);
        check("t5_err", rsp_err, 1);
        check("t5_result", rsp_result, 0);
        drain(20, "t5_drain");
        expect_tmo = 0;
`else
        push(8'h07, 8'h09, 3'b010, 5, ok);
        repeat (40) @(negedge clk);
        check("t5_start_held", alu_start, 1);
        check("t5_no_rsp", rsp_valid, 0);
        @(posedge clk); #1;
`endif

        // 6: async reset while waiting
        push(8'h33, 8'h44, 3'b011, 5, ok);
        repeat (5) @(posedge clk);
        #2; reset_n = 1'b0;
        #1;
        check("t6_start", alu_start, 0);
        check("t6_alu_reset_n", alu_reset_n, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_alu_ab", {alu_a, alu_b}, 0);
        exp_q.delete();
        @(posedge clk); #1; reset_n = 1'b1;
        st = 0;
        repeat (6) begin
            @(negedge clk);
            if (alu_start) st++;
        end
        check("t6_fifo_empty", st, 0);
        check("t6_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        fixed_lat = 2;
        push(8'h10, 8'h30, 3'b011, 5, ok);
        measure(n, found, sa, sb, s_at);
        check("t6_start_len", n, 2);
        check("t6_result", rsp_result, 16'h0020);
        drain(20, "t6_drain");

        // random mix against the reference model
        fixed_lat = 0; rr_random = 1;
        for (int i = 0; i < 80; i++) begin
            push(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 60, ok);
            check("rand_push", ok, 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        #1; rr_random = 0; rsp_ready = 1'b1;
        drain(300, "rand_drain");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
